// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Two prioritised write ports (port 1 wins), NRD combinational reads, optional write bypass.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [1:0]          wr_en_i,
    input  logic [2*AW-1:0]     wr_addr_i,
    input  logic [2*XLEN-1:0]   wr_data_i,
    input  logic [1:0]          wr_clr_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                flush_i,
    output logic [2**AW-1:0]    busy_vec_o
);
    localparam int NREG = 2**AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr_hit;
    logic [NREG-1:0] iss_hit;
    logic [AW-1:0]   wr_addr [2];
    logic [XLEN-1:0] wr_data [2];
    logic [AW-1:0]   rd_addr [NRD];

    for (genvar p = 0; p < 2; p++) begin : g_wr_unpack
        assign wr_addr[p] = wr_addr_i[p*AW +: AW];
        assign wr_data[p] = wr_data_i[p*XLEN +: XLEN];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_unpack
        assign rd_addr[k] = rd_addr_i[k*AW +: AW];
    end

    // Per-register clear comes from the winning writer, so port 1's clr overrides port 0's.
    always_comb begin
        clr_hit = '0;
        iss_hit = '0;
        for (int p = 0; p < 2; p++) begin
            if (wr_en_i[p]) begin
                clr_hit[wr_addr[p]] = wr_clr_i[p];
            end
        end
        if (iss_en_i) begin
            iss_hit[iss_addr_i] = 1'b1;
        end
        clr_hit[0] = 1'b0;
        iss_hit[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en_i[p] && (wr_addr[p] != '0)) begin
                    regs[wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush_i) begin
            busy <= '0;
        end else begin
            busy <= iss_hit | (busy & ~clr_hit);
        end
    end

    assign busy_vec_o = busy;

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rst_n && (rd_addr[k] != '0)) begin
                rd_data_o[k*XLEN +: XLEN] = regs[rd_addr[k]];
                rd_busy_o[k]              = busy[rd_addr[k]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < 2; p++) begin
                        if (wr_en_i[p] && (wr_addr[p] == rd_addr[k])) begin
                            rd_data_o[k*XLEN +: XLEN] = wr_data[p];
                        end
                    end
                    // A retiring producer frees the register unless a new one issues now.
                    if (clr_hit[rd_addr[k]] && !iss_hit[rd_addr[k]]) begin
                        rd_busy_o[k] = 1'b0;
                    end
                end
            end
        end
    end

endmodule
